// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - load-type codes, FSM encodings and alignment rule for the data-memory bridge
package dmem_bridge_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_REQ  = 2'd1;
    localparam logic [1:0] DMEM_WAIT = 2'd2;
    localparam logic [1:0] DMEM_DONE = 2'd3;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Stores are judged by their lane pattern, loads by address vs. access size.
    function automatic logic access_misaligned(input logic [3:0] we,
                                               input logic [2:0] ld_type,
                                               input logic [1:0] lane);
        if (we != 4'b0000) begin
            case (we)
                4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0011, 4'b1100, 4'b1111: return 1'b0;
                default:                   return 1'b1;
            endcase
        end
        case (ld_type)
            LT_LH, LT_LHU: return lane[0];
            LT_LW:         return lane != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bridge_load_aligner.sv
// rtl/dmem_bridge_load_aligner.sv - selects and extends the addressed byte/half of a raw read word
module dmem_bridge_load_aligner
    import dmem_bridge_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (ld_type_i)
            LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data_o = {24'h0, byte_sel};
            LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - mem-stage to ready/ack data-memory bus bridge with stall, watchdog and alignment error
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic [3:0]        mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [2:0]        ld_type_i,
    output logic              bus_req_o,
    output logic [3:0]        bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic              stallreq_o
);

    logic [1:0]        state_q, state_d;
    logic [3:0]        we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        ldt_q, ldt_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              misaligned;
    logic              in_flight;
    logic              done;
    logic [31:0]       fmt_data;

    assign misaligned = access_misaligned(mem_we_i, ld_type_i, mem_addr_i[1:0]);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ldt_d   = ldt_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMEM_IDLE: begin
                if (mem_ce_i) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = DMEM_DONE;
                    end else begin
                        we_d    = mem_we_i;
                        addr_d  = mem_addr_i;
                        wdata_d = mem_data_i;
                        ldt_d   = ld_type_i;
                        err_d   = 1'b0;
                        cnt_d   = 16'h0;
                        state_d = DMEM_REQ;
                    end
                end
            end
            DMEM_REQ, DMEM_WAIT: begin
                if (bus_ack_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = DMEM_DONE;
                end else if (state_q == DMEM_REQ) begin
                    state_d = DMEM_WAIT;
                end else begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'h1;
                    // The current WAIT cycle is the TIMEOUT_CYCLES-th one without an ack.
                    if (cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        state_d = DMEM_DONE;
                    end
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            we_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ldt_q   <= LT_LB;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ldt_q   <= ldt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    dmem_bridge_load_aligner u_aligner (
        .rdata_i   (rdata_q),
        .lane_i    (addr_q[1:0]),
        .ld_type_i (ldt_q),
        .data_o    (fmt_data)
    );

    assign in_flight     = (state_q == DMEM_REQ) || (state_q == DMEM_WAIT);
    assign done          = (state_q == DMEM_DONE);
    assign bus_req_o     = in_flight;
    assign bus_we_o      = we_q;
    assign bus_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_wdata_o   = wdata_q;
    assign rdata_valid_o = done && !err_q && (we_q == 4'h0);
    assign err_o         = done && err_q;
    assign rdata_o       = rdata_valid_o ? fmt_data : ZERO_WORD;
    assign stallreq_o    = ((state_q == DMEM_IDLE) && mem_ce_i) || in_flight;

endmodule
